// File: rtl/ant_maze_env_pkg.sv
// Shared encodings for the ant maze environment: move commands, headings, pheromone width, FSM states.
package ant_maze_env_pkg;

  localparam logic [1:0] MV_HALT    = 2'd0;
  localparam logic [1:0] MV_RIGHT   = 2'd1;
  localparam logic [1:0] MV_LEFT    = 2'd2;
  localparam logic [1:0] MV_FORWARD = 2'd3;

  localparam logic [1:0] HD_N = 2'd0;
  localparam logic [1:0] HD_E = 2'd1;
  localparam logic [1:0] HD_S = 2'd2;
  localparam logic [1:0] HD_W = 2'd3;

  localparam int PH_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_ESCAPED,
    ST_TIMEOUT
  } state_t;

endpackage

// File: rtl/ant_maze_map.sv
// Wall map regfile: one write port, async reads of the current cell ORed with the grid boundary,
// returning the wall on the ant's left and the wall straight ahead.
module ant_maze_map
  import ant_maze_env_pkg::*;
#(
  parameter int GRID_W = 8,
  parameter int GRID_H = 8,
  localparam int AW = $clog2(GRID_W * GRID_H),
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    wdata,
  input  logic [XW-1:0] pos_x,
  input  logic [YW-1:0] pos_y,
  input  logic [1:0]    heading,
  output logic          wall_left,
  output logic          wall_front
);

  localparam int CELLS = GRID_W * GRID_H;

  // Deliberately no reset: the maze configuration survives rst.
  logic [3:0] map_q [CELLS];

  logic [AW-1:0] rd_idx;
  logic [3:0]    bnd;
  logic [3:0]    walls;
  logic [1:0]    left_head;

  always_ff @(posedge clk) begin
    if (we) map_q[waddr] <= wdata;
  end

  assign rd_idx = AW'(int'(pos_y) * GRID_W + int'(pos_x));

  // Bit order {N,E,S,W}, so heading h lives at bit 3-h.
  assign bnd = {pos_y == '0, int'(pos_x) == GRID_W - 1, int'(pos_y) == GRID_H - 1, pos_x == '0};
  assign walls = map_q[rd_idx] | bnd;

  assign left_head  = heading - 2'd1;
  assign wall_front = walls[2'd3 - heading];
  assign wall_left  = walls[2'd3 - left_head];

endmodule

// File: rtl/ant_maze_env.sv
// Closed-loop maze world for the ant controller: position/heading FSM, step counter, pheromone
// memory; feelers are combinational from registered state so the controller can react same cycle.
module ant_maze_env
  import ant_maze_env_pkg::*;
#(
  parameter int GRID_W     = 8,
  parameter int GRID_H     = 8,
  parameter int START_X    = 0,
  parameter int START_Y    = 0,
  parameter int START_HEAD = 1,
  parameter int EXIT_X     = 7,
  parameter int EXIT_Y     = 7,
  parameter int MAX_STEPS  = 1023,
  localparam int AW = $clog2(GRID_W * GRID_H),
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H),
  localparam int SW = $clog2(MAX_STEPS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                cfg_we,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [3:0]          cfg_wall,
  input  logic [1:0]          move,
  output logic                ant_l,
  output logic                ant_r,
  output logic                hit,
  output logic                escape,
  output logic                timeout,
  output logic [XW-1:0]       pos_x,
  output logic [YW-1:0]       pos_y,
  output logic [1:0]          heading,
  output logic [SW-1:0]       step_cnt,
  input  logic [PH_WIDTH-1:0] ph_drop,
  output logic [PH_WIDTH-1:0] ph_detected
);

  localparam int CELLS = GRID_W * GRID_H;

  state_t              state_q, state_d;
  logic [XW-1:0]       x_q, x_d, ahead_x;
  logic [YW-1:0]       y_q, y_d, ahead_y;
  logic [1:0]          head_q, head_d;
  logic                hit_q, hit_d, esc_q, esc_d, to_q, to_d;
  logic [SW-1:0]       step_q, step_d;
  logic [PH_WIDTH-1:0] ph_q [CELLS];
  logic [PH_WIDTH-1:0] ph_d [CELLS];
  logic                ahead_ok, wall_left, wall_front, map_we;
  logic [AW-1:0]       cur_idx, ahead_idx;

  assign map_we = (state_q == ST_IDLE) && cfg_we && (int'(cfg_addr) < CELLS);

  ant_maze_map #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_map (
    .clk        (clk),
    .we         (map_we),
    .waddr      (cfg_addr),
    .wdata      (cfg_wall),
    .pos_x      (x_q),
    .pos_y      (y_q),
    .heading    (head_q),
    .wall_left  (wall_left),
    .wall_front (wall_front)
  );

  always_comb begin
    ahead_ok = 1'b1;
    ahead_x  = x_q;
    ahead_y  = y_q;
    case (head_q)
      HD_N:    if (y_q == '0) ahead_ok = 1'b0; else ahead_y = y_q - YW'(1);
      HD_E:    if (int'(x_q) == GRID_W - 1) ahead_ok = 1'b0; else ahead_x = x_q + XW'(1);
      HD_S:    if (int'(y_q) == GRID_H - 1) ahead_ok = 1'b0; else ahead_y = y_q + YW'(1);
      default: if (x_q == '0) ahead_ok = 1'b0; else ahead_x = x_q - XW'(1);
    endcase
  end

  assign cur_idx     = AW'(int'(y_q) * GRID_W + int'(x_q));
  assign ahead_idx   = AW'(int'(ahead_y) * GRID_W + int'(ahead_x));
  assign ph_detected = ahead_ok ? ph_q[ahead_idx] : '0;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    head_d  = head_q;
    hit_d   = 1'b0;
    esc_d   = esc_q;
    to_d    = to_q;
    step_d  = step_q;
    ph_d    = ph_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          if (int'(x_q) == EXIT_X && int'(y_q) == EXIT_Y) begin
            esc_d   = 1'b1;
            state_d = ST_ESCAPED;
          end
        end
      end
      ST_RUN: begin
        // Deposit lands in the cell occupied before this cycle's move.
        if (ph_drop != '0) ph_d[cur_idx] = ph_drop;
        case (move)
          MV_RIGHT:   head_d = head_q + 2'd1;
          MV_LEFT:    head_d = head_q - 2'd1;
          MV_FORWARD: begin
            if (wall_front) begin
              hit_d = 1'b1;
            end else begin
              x_d = ahead_x;
              y_d = ahead_y;
            end
          end
          default: ;
        endcase
        if (int'(step_q) < MAX_STEPS) step_d = step_q + SW'(1);
        // Reaching the exit takes priority over running out of steps.
        if (int'(x_d) == EXIT_X && int'(y_d) == EXIT_Y) begin
          esc_d   = 1'b1;
          state_d = ST_ESCAPED;
        end else if (int'(step_d) == MAX_STEPS) begin
          to_d    = 1'b1;
          state_d = ST_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= XW'(START_X);
      y_q     <= YW'(START_Y);
      head_q  <= 2'(START_HEAD);
      hit_q   <= 1'b0;
      esc_q   <= 1'b0;
      to_q    <= 1'b0;
      step_q  <= '0;
      ph_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      head_q  <= head_d;
      hit_q   <= hit_d;
      esc_q   <= esc_d;
      to_q    <= to_d;
      step_q  <= step_d;
      ph_q    <= ph_d;
    end
  end

  assign ant_l    = wall_left;
  assign ant_r    = wall_front;
  assign hit      = hit_q;
  assign escape   = esc_q;
  assign timeout  = to_q;
  assign pos_x    = x_q;
  assign pos_y    = y_q;
  assign heading  = head_q;
  assign step_cnt = step_q;

endmodule

// File: tb/tb_ant_maze_env.sv
// Bench for ant_maze_env on a 4x3 grid: directed scenarios then random episodes, every cycle
// compared against a cell/heading-level world model.
module tb_ant_maze_env;
  import ant_maze_env_pkg::*;

  localparam int GW = 4, GH = 3, EX = 3, EY = 2, MAXS = 40;

  logic       clk = 1'b0;
  logic       rst, start, cfg_we;
  logic [3:0] cfg_addr, cfg_wall;
  logic [1:0] move;
  logic       ant_l, ant_r, hit, escape, timeout;
  logic [1:0] pos_x, pos_y, heading;
  logic [5:0] step_cnt;
  logic [3:0] ph_drop, ph_detected;

  ant_maze_env #(
    .GRID_W(GW), .GRID_H(GH), .START_X(0), .START_Y(0), .START_HEAD(1),
    .EXIT_X(EX), .EXIT_Y(EY), .MAX_STEPS(MAXS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wall(cfg_wall), .move(move), .ant_l(ant_l), .ant_r(ant_r), .hit(hit),
    .escape(escape), .timeout(timeout), .pos_x(pos_x), .pos_y(pos_y), .heading(heading),
    .step_cnt(step_cnt), .ph_drop(ph_drop), .ph_detected(ph_detected)
  );

  always #5 clk = ~clk;

  // World model: mode 0 idle, 1 running, 2 escaped, 3 timed out.
  int         m_mode, m_x, m_y, m_h, m_steps;
  bit         m_hit, m_esc, m_to, map_ok;
  logic [3:0] m_wall [GW*GH];
  int         m_ph [GW*GH];
  int         total = 0, bad = 0;

  function automatic bit m_look(input int x, input int y, input int d, output int tx, output int ty);
    tx = x; ty = y;
    case (d)
      0: ty = y - 1;
      1: tx = x + 1;
      2: ty = y + 1;
      default: tx = x - 1;
    endcase
    return (tx >= 0 && tx < GW && ty >= 0 && ty < GH);
  endfunction

  function automatic bit m_blocked(input int x, input int y, input int d);
    int tx, ty;
    if (!m_look(x, y, d, tx, ty)) return 1'b1;
    return m_wall[y*GW + x][3-d];
  endfunction

  function automatic int m_ahead_ph();
    int tx, ty;
    if (!m_look(m_x, m_y, m_h, tx, ty)) return 0;
    return m_ph[ty*GW + tx];
  endfunction

  task automatic model_reset();
    m_mode = 0; m_x = 0; m_y = 0; m_h = 1; m_steps = 0;
    m_hit = 0; m_esc = 0; m_to = 0;
    foreach (m_ph[i]) m_ph[i] = 0;
  endtask

  task automatic model_clock();
    int tx, ty;
    bit nh;
    nh = 0;
    case (m_mode)
      0: begin
        if (cfg_we && int'(cfg_addr) < GW*GH) m_wall[cfg_addr] = cfg_wall;
        if (start) begin
          m_mode = 1;
          if (m_x == EX && m_y == EY) begin m_esc = 1; m_mode = 2; end
        end
      end
      1: begin
        if (ph_drop != 0) m_ph[m_y*GW + m_x] = int'(ph_drop);
        case (move)
          MV_RIGHT: m_h = (m_h + 1) % 4;
          MV_LEFT:  m_h = (m_h + 3) % 4;
          MV_FORWARD: begin
            if (m_blocked(m_x, m_y, m_h)) nh = 1;
            else if (m_look(m_x, m_y, m_h, tx, ty)) begin m_x = tx; m_y = ty; end
          end
          default: ;
        endcase
        m_steps++;
        if (m_x == EX && m_y == EY) begin m_esc = 1; m_mode = 2; end
        else if (m_steps == MAXS) begin m_to = 1; m_mode = 3; end
      end
      default: ;
    endcase
    m_hit = nh;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pos_x", 32'(pos_x), m_x);
    chk("pos_y", 32'(pos_y), m_y);
    chk("heading", 32'(heading), m_h);
    chk("hit", 32'(hit), 32'(m_hit));
    chk("escape", 32'(escape), 32'(m_esc));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("step_cnt", 32'(step_cnt), m_steps);
    chk("ph_detected", 32'(ph_detected), m_ahead_ph());
    if (map_ok) begin
      chk("ant_l", 32'(ant_l), 32'(m_blocked(m_x, m_y, (m_h + 3) % 4)));
      chk("ant_r", 32'(ant_r), 32'(m_blocked(m_x, m_y, m_h)));
    end
  endtask

  task automatic tick(input bit do_chk);
    @(posedge clk);
    model_clock();
    #1;
    if (do_chk) check_all();
  endtask

  // Pulses rst between clock edges, so it exercises the asynchronous path.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check_all();
    rst = 1'b0;
  endtask

  task automatic cfg_cell(input int addr, input logic [3:0] w);
    cfg_we = 1'b1; cfg_addr = 4'(addr); cfg_wall = w;
    tick(1'b1);
    cfg_we = 1'b0;
  endtask

  logic exp_l [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    int r;
    rst = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wall = '0;
    move = MV_HALT; ph_drop = '0; map_ok = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_pos_x", 32'(pos_x), 0);
    chk("rst_heading", 32'(heading), 1);
    chk("rst_step", 32'(step_cnt), 0);
    chk("rst_escape", 32'(escape), 0);
    rst = 1'b0;

    for (int i = 0; i < GW*GH; i++) begin
      cfg_we = 1'b1; cfg_addr = 4'(i); cfg_wall = 4'h0;
      tick(1'b0);
    end
    cfg_we = 1'b0;
    map_ok = 1'b1;
    cfg_cell(13, 4'hF);

    // Open corridor along row 0
    start = 1'b1; tick(1'b1); start = 1'b0;
    move = MV_FORWARD;
    repeat (3) tick(1'b1);
    chk("t1_pos_x", 32'(pos_x), 3);
    chk("t1_pos_y", 32'(pos_y), 0);
    chk("t1_step", 32'(step_cnt), 3);

    // Configured east wall blocks the first step
    move = MV_HALT;
    do_reset();
    cfg_cell(0, 4'b0100);
    start = 1'b1; tick(1'b1); start = 1'b0;
    chk("t2_ant_r", 32'(ant_r), 1);
    move = MV_FORWARD; tick(1'b1);
    chk("t2_hit", 32'(hit), 1);
    chk("t2_pos_x", 32'(pos_x), 0);
    move = MV_HALT; tick(1'b1);
    chk("t2_hit_clear", 32'(hit), 0);

    // Boundary feelers while spinning in the corner
    move = MV_LEFT; tick(1'b1);
    chk("t3_head_n", 32'(heading), 0);
    chk("t3_ant_r", 32'(ant_r), 1);
    chk("t3_ant_l", 32'(ant_l), 1);
    move = MV_RIGHT;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1);
      chk("t3_spin_l", 32'(ant_l), 32'(exp_l[i]));
    end
    chk("t3_head_back", 32'(heading), 0);

    // Walk to the exit; escape is sticky and freezes the ant
    move = MV_HALT;
    do_reset();
    cfg_cell(0, 4'b0000);
    start = 1'b1; tick(1'b1); start = 1'b0;
    move = MV_FORWARD; repeat (3) tick(1'b1);
    move = MV_RIGHT; tick(1'b1);
    move = MV_FORWARD; repeat (2) tick(1'b1);
    chk("t4_escape", 32'(escape), 1);
    chk("t4_pos_y", 32'(pos_y), 2);
    move = MV_LEFT; tick(1'b1);
    move = MV_FORWARD; repeat (2) tick(1'b1);
    chk("t4_pos_x_frozen", 32'(pos_x), 3);
    chk("t4_step_frozen", 32'(step_cnt), 6);
    chk("t4_escape_sticky", 32'(escape), 1);

    // Halting until the step budget runs out
    move = MV_HALT;
    do_reset();
    start = 1'b1; tick(1'b1); start = 1'b0;
    repeat (MAXS - 1) tick(1'b1);
    chk("t5_no_timeout_yet", 32'(timeout), 0);
    tick(1'b1);
    chk("t5_timeout", 32'(timeout), 1);
    chk("t5_step", 32'(step_cnt), MAXS);
    chk("t5_escape", 32'(escape), 0);
    repeat (3) tick(1'b1);
    chk("t5_step_hold", 32'(step_cnt), MAXS);

    // Pheromone deposit, detection, and reset clearing it but not the map
    do_reset();
    cfg_cell(1, 4'b0010);
    start = 1'b1; tick(1'b1); start = 1'b0;
    ph_drop = 4'd3; move = MV_FORWARD; tick(1'b1);
    ph_drop = 4'd0; move = MV_RIGHT; tick(1'b1);
    chk("t6_south_wall", 32'(ant_r), 1);
    tick(1'b1);
    chk("t6_ph_detected", 32'(ph_detected), 3);
    do_reset();
    chk("t6_rst_pos_x", 32'(pos_x), 0);
    chk("t6_rst_ph", 32'(ph_detected), 0);
    move = MV_HALT; start = 1'b1; tick(1'b1); start = 1'b0;
    move = MV_FORWARD; tick(1'b1);
    move = MV_RIGHT; tick(1'b1);
    chk("t6_map_kept", 32'(ant_r), 1);

    // Random episodes
    for (int ep = 0; ep < 25; ep++) begin
      move = MV_HALT; ph_drop = '0; start = 1'b0;
      do_reset();
      for (int i = 0; i < GW*GH; i++) cfg_cell(i, 4'($urandom & $urandom));
      start = 1'b1; tick(1'b1);
      for (int c = 0; c < 50; c++) begin
        start    = 1'($urandom_range(0, 1));
        cfg_we   = ($urandom_range(0, 7) == 0);
        cfg_addr = 4'($urandom);
        cfg_wall = 4'($urandom);
        r        = $urandom_range(0, 9);
        move     = (r < 5) ? MV_FORWARD : 2'(r % 3);
        ph_drop  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
        tick(1'b1);
        if (c == 30 && ep % 5 == 4) do_reset();
      end
      cfg_we = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
